// File: rtl/datapath_pkg.sv
// Shared datapath types for the matrix issue stage: state encoding, latched entry, tag constants.
package datapath_pkg;

  localparam int unsigned ISSUE_M_TAG_W = 2;
  localparam int unsigned ISSUE_M_RD_W  = 4;
  localparam int unsigned ISSUE_M_OP_W  = 2;

  // Tag value meaning "operand already available"
  localparam logic [ISSUE_M_TAG_W-1:0] TAG_READY = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ISSUE,
    EXEC
  } issue_m_state_t;

  typedef struct packed {
    logic [ISSUE_M_OP_W-1:0]  op;
    logic [ISSUE_M_RD_W-1:0]  md;
    logic [ISSUE_M_RD_W-1:0]  ms1;
    logic [ISSUE_M_RD_W-1:0]  ms2;
    logic                     spec;
    logic [ISSUE_M_TAG_W-1:0] t1;
    logic [ISSUE_M_TAG_W-1:0] t2;
  } issue_m_entry_t;

endpackage

// File: rtl/tag_wakeup.sv
// Combinational wakeup: clears a producer tag when a matching non-zero writeback is broadcast.
module tag_wakeup #(
  parameter int unsigned TAG_W = 2
) (
  input  logic [TAG_W-1:0] tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  output logic [TAG_W-1:0] tag_out
);

  always_comb begin
    tag_out = tag;
    if (wb_valid && (wb_tag == tag) && (tag != '0)) begin
      tag_out = '0;
    end
  end

endmodule

// File: rtl/issue_m.sv
// Matrix issue stage behind FUST-M: tag wakeup, FU handshake, spec flush/kill.
// Define ISSUE_M_PERF_EN to build the stall/issue perf counters.
module issue_m
  import datapath_pkg::*;
#(
  parameter int unsigned TAG_W = ISSUE_M_TAG_W,
  parameter int unsigned RD_W  = ISSUE_M_RD_W,
  parameter int unsigned OP_W  = ISSUE_M_OP_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             fust_busy,
  input  logic             fust_spec,
  input  logic [OP_W-1:0]  fust_op,
  input  logic [RD_W-1:0]  fust_md,
  input  logic [RD_W-1:0]  fust_ms1,
  input  logic [RD_W-1:0]  fust_ms2,
  input  logic [TAG_W-1:0] fust_t1,
  input  logic [TAG_W-1:0] fust_t2,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic             flush,
  input  logic             spec_clr,
  input  logic             fu_ready,
  input  logic             fu_done,
  output logic [TAG_W-1:0] t1_out,
  output logic [TAG_W-1:0] t2_out,
  output logic             busy_clr,
  output logic             fu_valid,
  output logic [OP_W-1:0]  fu_op,
  output logic [RD_W-1:0]  fu_md,
  output logic [RD_W-1:0]  fu_ms1,
  output logic [RD_W-1:0]  fu_ms2,
  output logic             fu_kill,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  issue_m_state_t state_q, state_d;
  issue_m_entry_t ent_q, ent_d;

  logic [TAG_W-1:0] cur_t1, cur_t2;
  logic [TAG_W-1:0] wake_t1, wake_t2;
  logic             kill_spec;
  logic             ops_ready;

  // In IDLE the wakeup looks at the incoming row so a same-cycle broadcast is bypassed
  assign cur_t1 = (state_q == IDLE) ? fust_t1 : ent_q.t1;
  assign cur_t2 = (state_q == IDLE) ? fust_t2 : ent_q.t2;

  tag_wakeup #(
    .TAG_W (TAG_W)
  ) u_wake_t1 (
    .tag      (cur_t1),
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag),
    .tag_out  (wake_t1)
  );

  tag_wakeup #(
    .TAG_W (TAG_W)
  ) u_wake_t2 (
    .tag      (cur_t2),
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag),
    .tag_out  (wake_t2)
  );

  assign kill_spec = flush && ent_q.spec;
  assign ops_ready = (wake_t1 == TAG_READY) && (wake_t2 == TAG_READY);

  always_comb begin
    state_d  = state_q;
    ent_d    = ent_q;
    busy_clr = 1'b0;
    fu_valid = 1'b0;
    fu_kill  = 1'b0;

    if (state_q != IDLE) begin
      ent_d.t1 = wake_t1;
      ent_d.t2 = wake_t2;
      if (spec_clr) begin
        ent_d.spec = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        // A speculative row arriving alongside a flush is already dead
        if (fust_busy && !(flush && fust_spec)) begin
          ent_d.op   = fust_op;
          ent_d.md   = fust_md;
          ent_d.ms1  = fust_ms1;
          ent_d.ms2  = fust_ms2;
          ent_d.spec = fust_spec;
          ent_d.t1   = wake_t1;
          ent_d.t2   = wake_t2;
          state_d    = ops_ready ? ISSUE : WAIT;
        end
      end
      WAIT: begin
        if (kill_spec) begin
          state_d  = IDLE;
          busy_clr = 1'b1;
        end else if (ops_ready) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (kill_spec) begin
          state_d  = IDLE;
          busy_clr = 1'b1;
        end else begin
          fu_valid = 1'b1;
          if (fu_ready) begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (kill_spec) begin
          state_d  = IDLE;
          fu_kill  = 1'b1;
          busy_clr = 1'b1;
        end else if (fu_done) begin
          state_d  = IDLE;
          busy_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
    end
  end

  assign t1_out = (state_q == IDLE) ? wake_t1 : ent_q.t1;
  assign t2_out = (state_q == IDLE) ? wake_t2 : ent_q.t2;
  assign fu_op  = ent_q.op;
  assign fu_md  = ent_q.md;
  assign fu_ms1 = ent_q.ms1;
  assign fu_ms2 = ent_q.ms2;

`ifdef ISSUE_M_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, issue_cnt_q;

  // Saturating counters: hold at all-ones
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      if ((state_q == WAIT) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (fu_valid && fu_ready && (issue_cnt_q != '1)) begin
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;
`else
  assign stall_cnt = '0;
  assign issue_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_m.sv
// Self-checking bench for issue_m: per-cycle vector table plus an issue scoreboard.
module tb_issue_m;

`ifdef ISSUE_M_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       CLK, nRST;
  logic       fust_busy, fust_spec;
  logic [1:0] fust_op;
  logic [3:0] fust_md, fust_ms1, fust_ms2;
  logic [1:0] fust_t1, fust_t2;
  logic       wb_valid;
  logic [1:0] wb_tag;
  logic       flush, spec_clr, fu_ready, fu_done;
  logic [1:0] t1_out, t2_out;
  logic       busy_clr, fu_valid, fu_kill;
  logic [1:0] fu_op;
  logic [3:0] fu_md, fu_ms1, fu_ms2;
  logic [7:0] stall_cnt, issue_cnt;

  issue_m dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .fust_busy (fust_busy),
    .fust_spec (fust_spec),
    .fust_op   (fust_op),
    .fust_md   (fust_md),
    .fust_ms1  (fust_ms1),
    .fust_ms2  (fust_ms2),
    .fust_t1   (fust_t1),
    .fust_t2   (fust_t2),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .flush     (flush),
    .spec_clr  (spec_clr),
    .fu_ready  (fu_ready),
    .fu_done   (fu_done),
    .t1_out    (t1_out),
    .t2_out    (t2_out),
    .busy_clr  (busy_clr),
    .fu_valid  (fu_valid),
    .fu_op     (fu_op),
    .fu_md     (fu_md),
    .fu_ms1    (fu_ms1),
    .fu_ms2    (fu_ms2),
    .fu_kill   (fu_kill),
    .stall_cnt (stall_cnt),
    .issue_cnt (issue_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int busy, spec, op, md, ms1, ms2, t1, t2, wbv, wbt, flush, sclr, rdy, done, push;
    int e_valid, e_bclr, e_kill, e_t1, e_t2, e_stall, e_issue;
  } vec_t;

  typedef struct {
    int op, md, ms1, ms2;
  } iss_t;

  vec_t vecs[$];
  iss_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(int busy, int spec, int op, int md, int ms1, int ms2, int t1,
                              int t2, int wbv, int wbt, int flush, int sclr, int rdy, int done,
                              int push, int ev, int eb, int ek, int et1, int et2, int es,
                              int ei);
    vec_t v;
    v.busy = busy; v.spec = spec; v.op = op; v.md = md; v.ms1 = ms1; v.ms2 = ms2;
    v.t1 = t1; v.t2 = t2; v.wbv = wbv; v.wbt = wbt; v.flush = flush; v.sclr = sclr;
    v.rdy = rdy; v.done = done; v.push = push;
    v.e_valid = ev; v.e_bclr = eb; v.e_kill = ek; v.e_t1 = et1; v.e_t2 = et2;
    v.e_stall = es; v.e_issue = ei;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fust_busy = v.busy[0]; fust_spec = v.spec[0]; fust_op = v.op[1:0];
    fust_md = v.md[3:0]; fust_ms1 = v.ms1[3:0]; fust_ms2 = v.ms2[3:0];
    fust_t1 = v.t1[1:0]; fust_t2 = v.t2[1:0]; wb_valid = v.wbv[0]; wb_tag = v.wbt[1:0];
    flush = v.flush[0]; spec_clr = v.sclr[0]; fu_ready = v.rdy[0]; fu_done = v.done[0];
    if (v.push != 0) sb.push_back('{op: v.op, md: v.md, ms1: v.ms1, ms2: v.ms2});
  endtask

  // Compare issued fields against the oldest expected op; retire it on handshake
  task automatic sb_check(input string tag);
    iss_t e;
    if (fu_valid) begin
      if (sb.size() == 0) begin
        chk({tag, " unexpected issue"}, 1, 0);
      end else begin
        e = sb[0];
        chk({tag, " fu_op"}, int'(fu_op), e.op);
        chk({tag, " fu_md"}, int'(fu_md), e.md);
        chk({tag, " fu_ms1"}, int'(fu_ms1), e.ms1);
        chk({tag, " fu_ms2"}, int'(fu_ms2), e.ms2);
        if (fu_ready) void'(sb.pop_front());
      end
    end
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk({tag, " fu_valid"}, int'(fu_valid), v.e_valid);
    chk({tag, " busy_clr"}, int'(busy_clr), v.e_bclr);
    chk({tag, " fu_kill"}, int'(fu_kill), v.e_kill);
    chk({tag, " t1_out"}, int'(t1_out), v.e_t1);
    chk({tag, " t2_out"}, int'(t2_out), v.e_t2);
    chk({tag, " stall_cnt"}, int'(stall_cnt), PERF ? v.e_stall : 0);
    chk({tag, " issue_cnt"}, int'(issue_cnt), PERF ? v.e_issue : 0);
    sb_check(tag);
  endtask

  vec_t idle;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

    // busy spec op md ms1 ms2 t1 t2 | wbv wbt flush sclr rdy done push | v b k t1 t2 stall issue
    // Ready at dispatch, then done; fu_done in IDLE ignored
    vecs.push_back(mk(1,0,1,5,6,7,0,0, 0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0, 1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0, 0,1,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0, 0,0,0,0,0,0,1));
    // Wakeup ordering: t1=2 t2=3, wb 3 at cycle 2, wb 2 at cycle 5
    vecs.push_back(mk(1,0,2,8,9,10,2,3, 0,0,0,0,0,0,1, 0,0,0,2,3,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,2,3,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,3,0,0,0,0,0, 0,0,0,2,3,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0, 0,0,0,2,0,2,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,2,0,3,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,2,0,0,0,0,0, 0,0,0,2,0,4,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,0,0,0,0,5,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0, 1,0,0,0,0,5,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0, 0,1,0,0,0,5,2));
    // Same-cycle bypass on capture
    vecs.push_back(mk(1,0,3,1,2,3,1,0, 1,1,0,0,0,0,1, 0,0,0,0,0,5,2));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0, 1,0,0,0,0,5,2));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0, 0,1,0,0,0,5,3));
    // Flush in WAIT
    vecs.push_back(mk(1,1,0,0,0,0,1,0, 0,0,0,0,0,0,0, 0,0,0,1,0,5,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,0,0,0, 0,1,0,1,0,5,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,6,3));
    // Flush in ISSUE with concurrent fu_ready
    vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,6,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,1,0,0, 0,1,0,0,0,6,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0, 0,0,0,0,0,6,3));
    // Spec row dropped under flush in IDLE; non-spec row unaffected by flush
    vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,0,1,0,0,0,0, 0,0,0,0,0,6,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0, 0,0,0,0,0,6,3));
    vecs.push_back(mk(1,0,1,2,3,4,0,0, 0,0,1,0,0,0,1, 0,0,0,0,0,6,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,0,0,0, 1,0,0,0,0,6,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0, 1,0,0,0,0,6,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,0,0,0, 0,0,0,0,0,6,4));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0, 0,1,0,0,0,6,4));
    // spec_clr then flush in EXEC: no kill
    vecs.push_back(mk(1,1,2,3,4,5,0,0, 0,0,0,0,0,0,1, 0,0,0,0,0,6,4));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0, 1,0,0,0,0,6,4));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,0,0,0, 0,0,0,0,0,6,5));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,0,0,0, 0,0,0,0,0,6,5));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0, 0,1,0,0,0,6,5));
    // Flush in EXEC while speculative: kill
    vecs.push_back(mk(1,1,3,6,7,8,0,0, 0,0,0,0,0,0,1, 0,0,0,0,0,6,5));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0, 1,0,0,0,0,6,5));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,0,0,0, 0,1,1,0,0,6,6));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0, 0,0,0,0,0,6,6));
    // Flush and spec_clr together: flush wins
    vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,6,6));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,1,0,0,0, 0,1,0,0,0,6,6));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0, 0,0,0,0,0,6,6));

    nRST = 1'b0;
    drive(idle);
    repeat (2) @(negedge CLK);
    #1;
    chk("reset fu_valid", int'(fu_valid), 0);
    chk("reset busy_clr", int'(busy_clr), 0);
    chk("reset fu_kill", int'(fu_kill), 0);
    chk("reset fu_md", int'(fu_md), 0);
    chk("reset stall_cnt", int'(stall_cnt), 0);
    chk("reset issue_cnt", int'(issue_cnt), 0);
    nRST = 1'b1;

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i]);
      #1;
      check_vec(vecs[i], $sformatf("row%0d", i));
    end

    // Long WAIT to saturate stall_cnt, then flush out the speculative op
    @(negedge CLK);
    drive(mk(1,1,0,0,0,0,1,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge CLK);
    drive(idle);
    repeat (299) @(negedge CLK);
    #1;
    chk("sat stall_cnt", int'(stall_cnt), PERF ? 255 : 0);
    chk("sat t1_out", int'(t1_out), 1);
    chk("sat fu_valid", int'(fu_valid), 0);
    flush = 1'b1;
    #1;
    chk("sat flush busy_clr", int'(busy_clr), 1);
    @(negedge CLK);
    drive(idle);

    // Reset while in EXEC
    drive(mk(1,0,1,15,14,13,0,0, 0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    @(negedge CLK);
    drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0, 0,0,0,0,0,0,0));
    #1;
    chk("rst-exec fu_valid", int'(fu_valid), 1);
    sb_check("rst-exec");
    @(negedge CLK);
    drive(idle);
    #1;
    chk("rst-exec issue_cnt", int'(issue_cnt), PERF ? 7 : 0);
    #2;
    nRST = 1'b0;
    #1;
    chk("rst-exec fu_valid low", int'(fu_valid), 0);
    chk("rst-exec busy_clr", int'(busy_clr), 0);
    chk("rst-exec fu_kill", int'(fu_kill), 0);
    chk("rst-exec fu_md", int'(fu_md), 0);
    chk("rst-exec stall_cnt", int'(stall_cnt), 0);
    chk("rst-exec issue_cnt 0", int'(issue_cnt), 0);
    @(negedge CLK);
    nRST = 1'b1;
    fu_done = 1'b1;
    #1;
    chk("post-rst done ignored", int'(busy_clr), 0);
    @(negedge CLK);
    drive(idle);

    chk("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
